// File: rtl/riscv_v_pkg.sv
// Shared definitions for the vector LMUL sequencer.
// Holds the vtype field offsets, geometry constants derived from NUM_BYTES,
// the LMUL decode helper and the micro-op record driven to execute.
// The geometry parameters live here so that every file sees the same
// widths. Retarget the sequencer by editing these values.
package riscv_v_pkg;

  localparam int NUM_BYTES = 16;                    // bytes per vector register
  localparam int MAX_LMUL  = 8;                     // largest register group
  localparam int VL_W      = 8;                     // vl / vstart width
  localparam int ADDR_W    = 5;                     // register address width

  localparam int LOG2_NB   = $clog2(NUM_BYTES);
  localparam int EPR_W     = $clog2(NUM_BYTES) + 1; // holds 1..NUM_BYTES
  localparam int PASS_W    = $clog2(MAX_LMUL);      // pass index 0..MAX_LMUL-1

  // vtype field offsets
  localparam int VT_VLMUL  = 0;                     // [2:0]
  localparam int VT_VSEW   = 3;                     // [5:3]
  localparam int VT_VTA    = 6;
  localparam int VT_VMA    = 7;
  localparam int VT_VILL   = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] srca_addr;
    logic [ADDR_W-1:0] srcb_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [EPR_W-1:0]  vstart;
    logic [EPR_W-1:0]  vl;
    logic              first;
    logic              last;
  } uop_t;

  // Fractional and reserved encodings collapse to a single pass.
  function automatic logic [PASS_W:0] lmul_decode(input logic [2:0] vlmul);
    case (vlmul)
      3'd0:    lmul_decode = (PASS_W+1)'(1);
      3'd1:    lmul_decode = (PASS_W+1)'(2);
      3'd2:    lmul_decode = (PASS_W+1)'(4);
      3'd3:    lmul_decode = (PASS_W+1)'(8);
      default: lmul_decode = (PASS_W+1)'(1);
    endcase
  endfunction

endpackage

// File: rtl/riscv_v_pass_calc.sv
// Combinational pass-range calculator.
// Inputs : vtype, vl, vstart of the offered request.
// Outputs: epr (elements per register), ps/pe (first/last pass index),
//          illegal (bad vtype), empty (no element falls in any pass).
// ps/pe are only meaningful when neither illegal nor empty is set.
module riscv_v_pass_calc
  import riscv_v_pkg::*;
(
  input  logic [8:0]        vtype,
  input  logic [VL_W-1:0]   vl,
  input  logic [VL_W-1:0]   vstart,
  output logic [EPR_W-1:0]  epr,
  output logic [PASS_W-1:0] ps,
  output logic [PASS_W-1:0] pe,
  output logic              illegal,
  output logic              empty
);

  logic [2:0]      vlmul;
  logic [2:0]      vsew;
  logic [2:0]      shift;     // log2(epr)
  logic [VL_W-1:0] ps_full;
  logic [VL_W:0]   npass_raw; // ceil(vl / epr)
  logic [VL_W:0]   lmul_ext;
  logic [VL_W:0]   npass;     // min(ceil(vl / epr), LMUL)

  always_comb begin
    vlmul   = vtype[VT_VLMUL +: 3];
    vsew    = vtype[VT_VSEW +: 3];
    illegal = vtype[VT_VILL] | (vlmul == 3'd4) | (vsew > 3'(LOG2_NB));
    // Clamp the shift for illegal widths so the arithmetic stays defined.
    shift   = (vsew > 3'(LOG2_NB)) ? 3'd0 : 3'(LOG2_NB) - vsew;
    epr     = EPR_W'(1) << shift;
    // epr is a power of two, so the divisions reduce to shifts.
    ps_full   = vstart >> shift;
    npass_raw = ({1'b0, vl} + (VL_W+1)'(epr) - (VL_W+1)'(1)) >> shift;
    lmul_ext  = (VL_W+1)'(lmul_decode(vlmul));
    npass     = (npass_raw < lmul_ext) ? npass_raw : lmul_ext;
    empty     = (vl == '0) | (vstart >= vl) | ({1'b0, ps_full} >= npass);
    ps        = ps_full[PASS_W-1:0];
    pe        = PASS_W'(npass - (VL_W+1)'(1));
  end

endmodule

// File: rtl/riscv_v_lmul_sequencer.sv
// Splits a grouped (LMUL>1) vector instruction into one micro-op per active
// register for a single-register execute stage.
// Request side : req_valid/req_ready handshake with vtype, vl, vstart, the
//                three base register addresses and their increment flags.
// Execute side : uop_valid/uop_ready handshake with per-pass addresses,
//                pass-local vstart/vl and first/last markers.
// Status       : busy, seq_done and seq_illegal (one-cycle pulses), flush.
//
// state  | meaning
// IDLE   | ready for a request; illegal/empty requests complete from here
// ISSUE  | emitting micro-ops for passes ps..pe
module riscv_v_lmul_sequencer
  import riscv_v_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [8:0]        req_vtype,
  input  logic [VL_W-1:0]   req_vl,
  input  logic [VL_W-1:0]   req_vstart,
  input  logic [ADDR_W-1:0] req_srca_addr,
  input  logic [ADDR_W-1:0] req_srcb_addr,
  input  logic [ADDR_W-1:0] req_dst_addr,
  input  logic              req_inc_srca,
  input  logic              req_inc_srcb,
  input  logic              req_inc_dst,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [ADDR_W-1:0] uop_srca_addr,
  output logic [ADDR_W-1:0] uop_srcb_addr,
  output logic [ADDR_W-1:0] uop_dst_addr,
  output logic [EPR_W-1:0]  uop_vstart,
  output logic [EPR_W-1:0]  uop_vl,
  output logic              uop_first,
  output logic              uop_last,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_illegal
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t state_q, state_d;

  logic [EPR_W-1:0]  calc_epr;
  logic [PASS_W-1:0] calc_ps, calc_pe;
  logic              calc_illegal, calc_empty;

  logic [ADDR_W-1:0] srca_q, srcb_q, dst_q;
  logic              inc_srca_q, inc_srcb_q, inc_dst_q;
  logic [VL_W-1:0]   vl_q, vstart_q;
  logic [EPR_W-1:0]  epr_q;
  logic [PASS_W-1:0] ps_q, pe_q, pass_q;
  logic              done_q, illegal_q;

  logic load, uop_fire, done_d, illegal_d;
  logic [VL_W-1:0] pass_base, remain;
  uop_t uop;

  // Tail-policy bits are carried in vtype but do not affect sequencing.
  logic unused_vtype;
  assign unused_vtype = req_vtype[VT_VTA] ^ req_vtype[VT_VMA];

  riscv_v_pass_calc u_pass_calc (
    .vtype   (req_vtype),
    .vl      (req_vl),
    .vstart  (req_vstart),
    .epr     (calc_epr),
    .ps      (calc_ps),
    .pe      (calc_pe),
    .illegal (calc_illegal),
    .empty   (calc_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    uop_fire  = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          if (calc_illegal)    illegal_d = 1'b1;
          else if (calc_empty) done_d    = 1'b1;
          else begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (flush) state_d = S_IDLE;
        else if (uop_ready) begin
          uop_fire = 1'b1;
          if (pass_q == pe_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      srca_q     <= '0;
      srcb_q     <= '0;
      dst_q      <= '0;
      inc_srca_q <= 1'b0;
      inc_srcb_q <= 1'b0;
      inc_dst_q  <= 1'b0;
      vl_q       <= '0;
      vstart_q   <= '0;
      epr_q      <= '0;
      ps_q       <= '0;
      pe_q       <= '0;
      pass_q     <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (load) begin
        srca_q     <= req_srca_addr;
        srcb_q     <= req_srcb_addr;
        dst_q      <= req_dst_addr;
        inc_srca_q <= req_inc_srca;
        inc_srcb_q <= req_inc_srcb;
        inc_dst_q  <= req_inc_dst;
        vl_q       <= req_vl;
        vstart_q   <= req_vstart;
        epr_q      <= calc_epr;
        ps_q       <= calc_ps;
        pe_q       <= calc_pe;
        pass_q     <= calc_ps;
      end else if (uop_fire && (pass_q != pe_q)) begin
        pass_q <= pass_q + PASS_W'(1);
      end
    end
  end

  // Micro-op fields are a pure function of the held pass index, so they
  // stay stable for as long as execute stalls.
  always_comb begin
    pass_base     = VL_W'(pass_q) * VL_W'(epr_q);
    remain        = vl_q - pass_base;
    uop.srca_addr = srca_q + (inc_srca_q ? ADDR_W'(pass_q) : '0);
    uop.srcb_addr = srcb_q + (inc_srcb_q ? ADDR_W'(pass_q) : '0);
    uop.dst_addr  = dst_q  + (inc_dst_q  ? ADDR_W'(pass_q) : '0);
    uop.vstart    = (pass_q == ps_q) ? EPR_W'(vstart_q - pass_base) : '0;
    uop.vl        = (remain > VL_W'(epr_q)) ? epr_q : EPR_W'(remain);
    uop.first     = (pass_q == ps_q);
    uop.last      = (pass_q == pe_q);
    // Stale latches from a finished sequence must not leak onto the bus.
    if (state_q != S_ISSUE) uop = '0;
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q == S_ISSUE);
  assign uop_valid     = busy;
  assign uop_srca_addr = uop.srca_addr;
  assign uop_srcb_addr = uop.srcb_addr;
  assign uop_dst_addr  = uop.dst_addr;
  assign uop_vstart    = uop.vstart;
  assign uop_vl        = uop.vl;
  assign uop_first     = uop.first;
  assign uop_last      = uop.last;
  assign seq_done      = done_q;
  assign seq_illegal   = illegal_q;

endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
module tb_riscv_v_lmul_sequencer;

  logic       clk = 1'b0;
  logic       rst, flush, req_valid, req_ready;
  logic [8:0] req_vtype;
  logic [7:0] req_vl, req_vstart;
  logic [4:0] req_srca_addr, req_srcb_addr, req_dst_addr;
  logic       req_inc_srca, req_inc_srcb, req_inc_dst;
  logic       uop_valid, uop_ready;
  logic [4:0] uop_srca_addr, uop_srcb_addr, uop_dst_addr;
  logic [4:0] uop_vstart, uop_vl;
  logic       uop_first, uop_last, busy, seq_done, seq_illegal;

  riscv_v_lmul_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_vtype(req_vtype),
    .req_vl(req_vl), .req_vstart(req_vstart),
    .req_srca_addr(req_srca_addr), .req_srcb_addr(req_srcb_addr),
    .req_dst_addr(req_dst_addr), .req_inc_srca(req_inc_srca),
    .req_inc_srcb(req_inc_srcb), .req_inc_dst(req_inc_dst),
    .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_srca_addr(uop_srca_addr), .uop_srcb_addr(uop_srcb_addr),
    .uop_dst_addr(uop_dst_addr), .uop_vstart(uop_vstart), .uop_vl(uop_vl),
    .uop_first(uop_first), .uop_last(uop_last), .busy(busy),
    .seq_done(seq_done), .seq_illegal(seq_illegal)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct { int srca, srcb, dst, vstart, vl, first, last; } uop_exp_t;
  uop_exp_t exp_q[$];

  typedef struct {
    int vlmul, vsew, vill, vl, vstart, a, b, d, ia, ib, id;
    int stall, exp_n, exp_ill;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: intersect each register's element window with
  // [vstart, vl) and emit one micro-op per non-empty intersection.
  task automatic build_model(input int vlmul, vsew, vill, vl, vstart, a, b, d,
                             input int ia, ib, id, output int ill);
    int epr, lmul, lo, hi;
    uop_exp_t u;
    exp_q.delete();
    ill = (vill != 0 || vlmul == 4 || vsew > 4) ? 1 : 0;
    if (ill) return;
    epr  = 16 >> vsew;
    lmul = (vlmul < 4) ? (1 << vlmul) : 1;
    for (int p = 0; p < lmul; p++) begin
      lo = (vstart > p * epr) ? vstart : p * epr;
      hi = (vl < (p + 1) * epr) ? vl : (p + 1) * epr;
      if (lo < hi) begin
        u.srca   = ia ? (a + p) % 32 : a;
        u.srcb   = ib ? (b + p) % 32 : b;
        u.dst    = id ? (d + p) % 32 : d;
        u.vstart = lo - p * epr;
        u.vl     = hi - p * epr;
        u.first  = 0;
        u.last   = 0;
        exp_q.push_back(u);
      end
    end
    if (exp_q.size() > 0) begin
      exp_q[0].first = 1;
      exp_q[exp_q.size() - 1].last = 1;
    end
  endtask

  task automatic drive_req(input int vlmul, vsew, vill, vl, vstart, a, b, d,
                           input int ia, ib, id);
    req_valid     = 1'b1;
    req_vtype     = {1'(vill), 2'($urandom), 3'(vsew), 3'(vlmul)};
    req_vl        = 8'(vl);
    req_vstart    = 8'(vstart);
    req_srca_addr = 5'(a);
    req_srcb_addr = 5'(b);
    req_dst_addr  = 5'(d);
    req_inc_srca  = 1'(ia);
    req_inc_srcb  = 1'(ib);
    req_inc_dst   = 1'(id);
  endtask

  task automatic scramble_req();
    req_valid     = 1'b0;
    req_vtype     = 9'($urandom);
    req_vl        = 8'($urandom);
    req_vstart    = 8'($urandom);
    req_srca_addr = 5'($urandom);
    req_srcb_addr = 5'($urandom);
    req_dst_addr  = 5'($urandom);
    req_inc_srca  = 1'($urandom);
    req_inc_srcb  = 1'($urandom);
    req_inc_dst   = 1'($urandom);
  endtask

  // Offers one request and follows it to completion. exp_n / exp_ill < 0
  // means take them from the reference model.
  task automatic run_req(input int vlmul, vsew, vill, vl, vstart, a, b, d,
                         input int ia, ib, id, stall_idx, rnd_ready,
                         input int exp_n, exp_ill);
    int ill, k, cyc, last_hs, stall_cnt, fin;
    build_model(vlmul, vsew, vill, vl, vstart, a, b, d, ia, ib, id, ill);
    if (exp_n < 0) exp_n = exp_q.size();
    if (exp_ill < 0) exp_ill = ill;
    @(negedge clk);
    chk("req_ready_before", req_ready, 1);
    drive_req(vlmul, vsew, vill, vl, vstart, a, b, d, ia, ib, id);
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    k = 0; cyc = 1; last_hs = -1; stall_cnt = 0; fin = 0;
    while (!fin && cyc < 300) begin
      if (cyc == 1) chk("uop_valid_n1", uop_valid, exp_q.size() > 0);
      if (seq_done) begin
        chk("done_cycle", cyc, ill ? -1 : (exp_q.size() == 0 ? 1 : last_hs + 1));
        fin = 1;
      end
      if (seq_illegal) begin
        chk("illegal_cycle", cyc, ill ? 1 : -1);
        fin = 1;
      end
      if (uop_valid) begin
        if (k < exp_q.size()) begin
          chk("uop_srca", uop_srca_addr, exp_q[k].srca);
          chk("uop_srcb", uop_srcb_addr, exp_q[k].srcb);
          chk("uop_dst", uop_dst_addr, exp_q[k].dst);
          chk("uop_vstart", uop_vstart, exp_q[k].vstart);
          chk("uop_vl", uop_vl, exp_q[k].vl);
          chk("uop_first", uop_first, exp_q[k].first);
          chk("uop_last", uop_last, exp_q[k].last);
        end else begin
          chk("extra_uop_index", k, exp_q.size() - 1);
        end
        if (k == stall_idx && stall_cnt < 3) begin
          uop_ready = 1'b0;
          stall_cnt++;
        end else begin
          uop_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (uop_ready) begin
          last_hs = cyc;
          k++;
        end
      end else begin
        uop_ready = 1'($urandom);
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("sequence_timeout_cycles", cyc, -1);
    chk("uop_count", k, exp_n);
    chk("illegal_seen", seq_illegal, exp_ill);
    chk("busy_after", busy, 0);
    chk("uop_valid_after", uop_valid, 0);
    @(negedge clk);
    chk("pulse_one_cycle", seq_done | seq_illegal, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            vlmul vsew vill vl  vst  a   b   d  ia ib id stall n ill
    tbl[0]  = '{2, 0, 0, 40,  0,  8, 16, 24, 1, 1, 1, -1, 3, 0};
    tbl[1]  = '{2, 0, 0, 40, 20,  8, 16, 24, 1, 1, 1, -1, 2, 0};
    tbl[2]  = '{3, 2, 0, 32,  0,  0, 10,  5, 1, 1, 0,  2, 8, 0};
    tbl[3]  = '{2, 0, 0,  0,  0,  8, 16, 24, 1, 1, 1, -1, 0, 0};
    tbl[4]  = '{2, 0, 1, 40,  0,  8, 16, 24, 1, 1, 1, -1, 0, 1};
    tbl[5]  = '{0, 0, 0, 40,  0,  3,  4,  5, 1, 1, 1, -1, 1, 0};
    tbl[6]  = '{2, 0, 0, 64,  0, 30, 12, 20, 1, 1, 1, -1, 4, 0};
    tbl[7]  = '{4, 0, 0, 40,  0,  1,  2,  3, 1, 1, 1, -1, 0, 1};
    tbl[8]  = '{1, 5, 0, 40,  0,  1,  2,  3, 1, 1, 1, -1, 0, 1};
    tbl[9]  = '{5, 0, 0, 10,  0,  7,  7,  7, 1, 0, 1, -1, 1, 0};
    tbl[10] = '{2, 0, 0, 10, 10,  1,  2,  3, 1, 1, 1, -1, 0, 0};
    tbl[11] = '{0, 0, 0, 40, 20,  1,  2,  3, 1, 1, 1, -1, 0, 0};
    tbl[12] = '{3, 4, 0,  5,  2, 31,  0,  0, 1, 1, 1, -1, 3, 0};

    rst = 1'b0; flush = 1'b0; uop_ready = 1'b0;
    scramble_req();
    #12;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_uop_valid", uop_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_seq_done", seq_done, 0);
    chk("reset_seq_illegal", seq_illegal, 0);
    chk("reset_uop_first", uop_first, 0);
    chk("reset_uop_vl", uop_vl, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i])
      run_req(tbl[i].vlmul, tbl[i].vsew, tbl[i].vill, tbl[i].vl, tbl[i].vstart,
              tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].ia, tbl[i].ib, tbl[i].id,
              tbl[i].stall, 0, tbl[i].exp_n, tbl[i].exp_ill);

    // Flush while the second micro-op is stalled.
    @(negedge clk);
    drive_req(2, 0, 0, 40, 0, 8, 16, 24, 1, 1, 1);
    uop_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    chk("flush_uop0_srca", uop_srca_addr, 8);
    @(negedge clk);
    uop_ready = 1'b0;
    chk("flush_uop1_srca", uop_srca_addr, 9);
    @(negedge clk);
    chk("flush_uop1_hold", uop_srca_addr, 9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_uop_valid", uop_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_req_ready", req_ready, 1);
    chk("flush_no_done", seq_done, 0);
    @(negedge clk);
    chk("flush_no_done_late", seq_done, 0);
    run_req(1, 1, 0, 16, 3, 4, 6, 8, 1, 1, 1, -1, 0, 2, 0);

    // Flush while idle blocks acceptance.
    @(negedge clk);
    drive_req(1, 0, 0, 20, 0, 1, 2, 3, 1, 1, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    scramble_req();
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_done", seq_done, 0);
    chk("idle_flush_ready", req_ready, 1);

    // Reset mid-sequence aborts without a done pulse.
    @(negedge clk);
    drive_req(3, 0, 0, 128, 0, 1, 2, 3, 1, 1, 1);
    @(posedge clk);
    @(negedge clk);
    scramble_req();
    uop_ready = 1'b1;
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_uop_valid", uop_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_no_done", seq_done, 0);

    // Randomized requests with random back-pressure.
    for (int n = 0; n < 60; n++) begin
      int vl, vs;
      vl = $urandom_range(0, 128);
      vs = ($urandom_range(0, 2) == 0) ? $urandom_range(0, vl + 8) : 0;
      run_req($urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 4),
              ($urandom_range(0, 9) == 0) ? 1 : 0, vl, vs,
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              -1, 1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_v_lmul_sequencer.md
Name: riscv_v_lmul_sequencer

Overview:
Sequences vector instructions with register grouping (LMUL>1) through the single-register (128-bit, 16-byte) vector execute stage.
- Accepts one decoded instruction per valid/ready handshake.
- Splits it into one micro-op per active register of the group.
- Each micro-op carries incremented register addresses and a pass-local vstart/vl.
- Sits between vector decode and execute; execute back-pressure stalls it via uop_ready.

Parameters:
NUM_BYTES, 16, bytes per vector register (VLEN/8); elements per register epr = NUM_BYTES >> vsew.
MAX_LMUL, 8, largest register group size.
VL_W, 8, width of vl/vstart (holds 0..NUM_BYTES*MAX_LMUL).
ADDR_W, 5, register address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
flush  in  1  kill in-flight sequence
req_valid  in  1  instruction offered
req_ready  out  1  sequencer can accept
req_vtype  in  9  [2:0] vlmul, [5:3] vsew, [6] vta, [7] vma, [8] vill
req_vl  in  VL_W  vector length
req_vstart  in  VL_W  start element
req_srca_addr  in  ADDR_W  base of srca group
req_srcb_addr  in  ADDR_W  base of srcb group
req_dst_addr  in  ADDR_W  base of destination group
req_inc_srca  in  1  srca is a vector group (increment per pass)
req_inc_srcb  in  1  srcb is a vector group
req_inc_dst  in  1  destination is a group (0 for mask/compare results)
uop_valid  out  1  micro-op valid
uop_ready  in  1  execute accepts micro-op
uop_srca_addr  out  ADDR_W  pass srca address
uop_srcb_addr  out  ADDR_W  pass srcb address
uop_dst_addr  out  ADDR_W  pass destination address
uop_vstart  out  $clog2(NUM_BYTES)+1  pass-local start element
uop_vl  out  $clog2(NUM_BYTES)+1  pass-local element count
uop_first  out  1  first micro-op of sequence
uop_last  out  1  last micro-op of sequence
busy  out  1  sequence in progress
seq_done  out  1  one-cycle pulse: sequence complete
seq_illegal  out  1  one-cycle pulse: request rejected for illegal vtype

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready=1. Internal counters and latches are cleared.
- States: IDLE, ISSUE.
- req_ready = (state==IDLE); there is no same-cycle bypass.
- Group size: vlmul 0/1/2/3 gives LMUL 1/2/4/8. vlmul 5/6/7 (fractional) is treated as 1 pass.
- Illegal requests: vill=1, vlmul=4, or vsew>log2(NUM_BYTES). Such a request is accepted, seq_illegal pulses at N+1, and no micro-op is issued.
- Pass range: start pass ps = vstart/epr. End pass pe = min(ceil(vl/epr), LMUL) - 1.
- Empty sequence: if vl==0 or vstart>=vl or ps>pe, the request is accepted, seq_done pulses at N+1, and there is no uop.
- Acceptance at edge N (IDLE & req_valid) → ISSUE. uop_valid=1 from N+1, starting with pass p=ps.
- Per pass p:
  - uop_srca_addr = srca + (inc_srca ? p : 0), mod 2^ADDR_W (wraps 31→0). srcb and dst are computed the same way.
  - uop_vstart = (p==ps) ? vstart - p*epr : 0.
  - uop_vl = min(vl - p*epr, epr).
  - uop_first = (p==ps); uop_last = (p==pe).
- Stalls: uop fields advance only on uop_valid & uop_ready. When uop_ready=0, all uop outputs hold stable.
- Completion: a handshake with uop_last=1 moves the state to IDLE and pulses seq_done next cycle. This gives one bubble between back-to-back sequences.
- busy = (state==ISSUE).
- Flush: takes priority over any handshake in the same cycle. On the next edge the state goes to IDLE, uop_valid=0, and seq_done/seq_illegal are not pulsed. A flush while IDLE also blocks acceptance that cycle.
- Latched fields are captured only at acceptance. Changes to req_* during ISSUE are ignored.
- Asserting rst mid-sequence aborts immediately with no done pulse.

Decomposition:
- riscv_v_pkg holds:
  - vtype field offsets;
  - the LMUL decode function;
  - NUM_BYTES-derived constants;
  - a uop struct (addresses, vstart, vl, first, last).
- Sub-module riscv_v_pass_calc is combinational: it takes vtype, vl, vstart and outputs epr, ps, pe, and the illegal/empty flags.

Test Plan:
1. vsew=0, vlmul=2, vl=40, vstart=0, a=8, b=16, d=24, all inc=1, uop_ready=1 → three uops:
   - (8,16,24, vs0, vl16, first);
   - (9,17,25, 0, 16);
   - (10,18,26, 0, 8, last).
   seq_done pulses the cycle after.
2. Same as 1 with vstart=20 → two uops: (9,17,25, vs4, vl16, first) then (10,18,26, 0, 8, last).
3. vsew=2, vlmul=3, vl=32, a=0, inc_dst=0, d=5 → eight uops, srca 0..7, vl=4 each, dst fixed at 5. uop_ready held low 3 cycles at the third uop → fields stable, no skip.
4. vl=0 → no uop_valid, seq_done at N+1. vill=1 → seq_illegal at N+1, no uop, no seq_done.
5. vlmul=0, vsew=0, vl=40 → single uop vl=16, first=last=1. a=30 with vlmul=2, vl=64 → srca 30,31,0,1.
6. Flush asserted while the second uop is stalled → uop_valid=0 and busy=0 next cycle, no seq_done, req_ready=1. A new request is then accepted normally.
